// File: rtl/pwm_current_ctrl_if.sv
// rtl/pwm_current_ctrl_if.sv - control/status bundle for the current-mode PWM controller
//
// Purpose: groups the run request, current set-point/estimate and the switch
// drive/status outputs of pwm_current_ctrl into one connection.
// Signals:
//   enable     run request (low = idle, also clears a latched fault)
//   i_target   requested coil current, ADC code (code ^ 0x7FF = signed DN)
//   iest_coil  estimated coil current, same format
//   pwm        switch drive, high = switch on
//   fault      latched over-current indication
//   state      IDLE=0, ON=1, OFF=2, FAULT=3
//   pulse_cnt  completed pulses since leaving IDLE, wraps
// Modports: master drives the requests (system/bench), slave is the controller.
interface pwm_current_ctrl_if;
  logic        enable;
  logic [11:0] i_target;
  logic [11:0] iest_coil;
  logic        pwm;
  logic        fault;
  logic [1:0]  state;
  logic [15:0] pulse_cnt;

  modport master (
    output enable, i_target, iest_coil,
    input  pwm, fault, state, pulse_cnt
  );

  modport slave (
    input  enable, i_target, iest_coil,
    output pwm, fault, state, pulse_cnt
  );
endinterface

// File: rtl/pwm_current_ctrl.sv
// rtl/pwm_current_ctrl.sv - hysteretic current-mode PWM controller with min/max timing and over-current trip
//
// Purpose: drives a coil switch so the estimated coil current stays inside
// i_target +/- HYST. The switch is held on for at least MIN_ON and at most
// MAX_ON cycles and off for at least MIN_OFF cycles. An estimate at or above
// I_LIMIT trips a latched fault that only enable=0 clears.
// Ports:
//   clk    clock (48 MHz)
//   reset  synchronous, active-high
//   bus    pwm_current_ctrl_if.slave: enable, i_target, iest_coil in;
//          pwm, fault, state, pulse_cnt out (all outputs registered)
module pwm_current_ctrl #(
  parameter int MIN_ON  = 24,
  parameter int MIN_OFF = 24,
  parameter int MAX_ON  = 480,
  parameter int HYST    = 21,
  parameter int I_LIMIT = 1845
) (
  input  logic               clk,
  input  logic               reset,
  pwm_current_ctrl_if.slave  bus
);

  generate
    if (MIN_ON < 1 || MIN_OFF < 1 || MIN_ON > MAX_ON) begin : g_bad_params
      $error("pwm_current_ctrl: parameters need 1 <= MIN_ON <= MAX_ON and MIN_OFF >= 1");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ON    = 2'd1;
  localparam logic [1:0] ST_OFF   = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  // One counter width serves both phases; it must hold the larger of the
  // on-time ceiling and the off-time saturation value.
  localparam int CNT_MAX = (MAX_ON > MIN_OFF) ? MAX_ON : MIN_OFF;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MIN_ON_C  = CW'(MIN_ON);
  localparam logic [CW-1:0] MIN_OFF_C = CW'(MIN_OFF);
  localparam logic [CW-1:0] MAX_ON_C  = CW'(MAX_ON);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  localparam logic signed [12:0] HYST_S = 13'(HYST);
  localparam logic signed [12:0] ILIM_S = 13'(I_LIMIT);

  logic [1:0]    state_q;
  logic [1:0]    state_nx;
  logic [CW-1:0] on_cnt_q;
  logic [CW-1:0] off_cnt_q;
  logic [15:0]   pulse_cnt_q;
  logic          pwm_q;
  logic          fault_q;

  // Current decode: flipping the low 11 bits turns the offset ADC code into
  // two's complement. Extending to 13 bits keeps target +/- HYST from
  // wrapping at either end of the 12-bit range.
  logic [11:0]        meas_tc;
  logic [11:0]        tgt_tc;
  logic signed [12:0] i_meas;
  logic signed [12:0] i_tgt;
  logic signed [12:0] lo_th;
  logic signed [12:0] hi_th;
  logic               over_current;

  assign meas_tc = bus.iest_coil ^ 12'h7FF;
  assign tgt_tc  = bus.i_target ^ 12'h7FF;
  assign i_meas  = $signed({meas_tc[11], meas_tc});
  assign i_tgt   = $signed({tgt_tc[11], tgt_tc});
  assign lo_th   = i_tgt - HYST_S;
  assign hi_th   = i_tgt + HYST_S;
  assign over_current = (i_meas >= ILIM_S);

  // Next-state decision. Dropping enable wins over everything, so a fault
  // can always be cleared; otherwise over-current wins over the timing rules.
  always_comb begin
    state_nx = state_q;
    if (!bus.enable) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_nx = over_current ? ST_FAULT : ST_OFF;
        end
        ST_OFF: begin
          if (over_current)
            state_nx = ST_FAULT;
          else if (off_cnt_q >= MIN_OFF_C && i_meas <= lo_th)
            state_nx = ST_ON;
        end
        ST_ON: begin
          if (over_current)
            state_nx = ST_FAULT;
          else if ((on_cnt_q >= MIN_ON_C && i_meas >= hi_th) || on_cnt_q == MAX_ON_C)
            state_nx = ST_OFF;
        end
        ST_FAULT: begin
          state_nx = ST_FAULT;
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // pwm and fault are registered copies of the decoded next state, so they
  // switch on the same edge as state and never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      on_cnt_q    <= '0;
      off_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      pwm_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q <= state_nx;
      pwm_q   <= (state_nx == ST_ON);
      fault_q <= (state_nx == ST_FAULT);

      unique case (state_nx)
        ST_OFF: begin
          on_cnt_q <= '0;
          // Coming out of IDLE the switch has been off indefinitely, so the
          // off-time minimum is treated as already met.
          if (state_q == ST_IDLE)
            off_cnt_q <= MIN_OFF_C;
          else if (state_q != ST_OFF)
            off_cnt_q <= ONE_C;
          else if (off_cnt_q < MIN_OFF_C)
            off_cnt_q <= off_cnt_q + ONE_C;
        end
        ST_ON: begin
          off_cnt_q <= '0;
          if (state_q == ST_ON)
            on_cnt_q <= on_cnt_q + ONE_C;
          else
            on_cnt_q <= ONE_C;
        end
        default: begin
          on_cnt_q  <= '0;
          off_cnt_q <= '0;
        end
      endcase

      // The pulse count restarts when a run begins and is kept through IDLE
      // so an aborted run can still be read back. Only an ON->OFF transition
      // completes a pulse; aborts and trips do not count.
      if (state_q == ST_IDLE && state_nx != ST_IDLE)
        pulse_cnt_q <= '0;
      else if (state_q == ST_ON && state_nx == ST_OFF)
        pulse_cnt_q <= pulse_cnt_q + 16'd1;
    end
  end

  assign bus.pwm       = pwm_q;
  assign bus.fault     = fault_q;
  assign bus.state     = state_q;
  assign bus.pulse_cnt = pulse_cnt_q;

endmodule
